// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the datapath store path and a
// single-port data memory. Stores are accepted at once and drained one word
// per cycle whenever the memory port is not busy with a load.
// Optional feature macro: STORE_BUF_FWD_EN
//   defined   -> loads that hit a pending store are served from the buffer
//   undefined -> loads that hit a pending store stall until it has drained
module store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_st_valid,
  input  logic [ADDR_WIDTH-1:0] i_st_addr,
  input  logic [DATA_WIDTH-1:0] i_st_data,
  output logic                  o_st_ready,
  input  logic                  i_ld_valid,
  input  logic [ADDR_WIDTH-1:0] i_ld_addr,
  output logic [DATA_WIDTH-1:0] o_ld_data,
  output logic                  o_ld_stall,
  output logic                  o_empty,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_mem_wr,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_drain;
  logic w_hit;
  logic w_stall;
`ifdef STORE_BUF_FWD_EN
  logic [DATA_WIDTH-1:0] w_fwd_data;
`endif

  // Status is derived only from the registered count, so ready/empty never
  // depend on same-cycle inputs.
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign o_st_ready = !w_full;
  assign o_empty    = w_empty;
  assign w_push     = i_st_valid && !w_full;

  // Scan valid entries oldest to youngest; a later match overrides an
  // earlier one so the forwarded value is always the youngest store.
  always_comb begin
    w_hit = 1'b0;
`ifdef STORE_BUF_FWD_EN
    w_fwd_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) &&
          (r_addr[r_rd_ptr + PTR_W'(i)] == i_ld_addr)) begin
        w_hit = 1'b1;
`ifdef STORE_BUF_FWD_EN
        w_fwd_data = r_data[r_rd_ptr + PTR_W'(i)];
`endif
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  assign w_stall = 1'b0;
`else
  assign w_stall = i_ld_valid && w_hit;
`endif

  // A stalled load gives the port back to the buffer so the hit entry can
  // drain; this guarantees the stall clears within count cycles.
  assign w_drain    = !w_empty && (!i_ld_valid || w_stall);
  assign o_ld_stall = w_stall;

  // Steer the single memory port between drain writes and load reads, and
  // select the load result (zero whenever no load completes).
  always_comb begin
    o_mem_wr   = 1'b0;
    o_mem_addr = '0;
    o_mem_data = '0;
    o_ld_data  = '0;
    if (w_drain) begin
      o_mem_wr   = 1'b1;
      o_mem_addr = r_addr[r_rd_ptr];
      o_mem_data = r_data[r_rd_ptr];
    end else if (i_ld_valid) begin
      o_mem_addr = i_ld_addr;
    end
    if (i_ld_valid && !w_stall) begin
`ifdef STORE_BUF_FWD_EN
      o_ld_data = w_hit ? w_fwd_data : i_mem_rdata;
`else
      o_ld_data = i_mem_rdata;
`endif
    end
  end

  // Pointer and occupancy bookkeeping; reset discards every pending store.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_drain) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: only entries covered by count are read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= i_st_addr;
      r_data[r_wr_ptr] <= i_st_data;
    end
  end

endmodule
